// File: rtl/coin_pulse_conditioner_pkg.sv
// Shared types and constants for the coin pulse conditioner:
// issue FSM encoding, channel indices and a counter-width helper.
package coin_pulse_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GAP   = 2'b10
  } issue_state_e;

  localparam int unsigned NUM_CH        = 3;
  localparam int unsigned CH_FIVE       = 0;
  localparam int unsigned CH_TEN        = 1;
  localparam int unsigned CH_TWENTYFIVE = 2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coin_pulse_conditioner_if.sv
// Sensor/feedback inputs and coin pulse outputs of the conditioner.
// master drives the sensors and product feedback; slave is the conditioner.
interface coin_pulse_conditioner_if;

  logic rawFive;
  logic rawTen;
  logic rawTwentyFive;
  logic theProduct;
  logic fiveRupees;
  logic tenRupees;
  logic twentyFiveRupees;
  logic coinReturn;

  modport master (
    output rawFive, rawTen, rawTwentyFive, theProduct,
    input  fiveRupees, tenRupees, twentyFiveRupees, coinReturn
  );

  modport slave (
    input  rawFive, rawTen, rawTwentyFive, theProduct,
    output fiveRupees, tenRupees, twentyFiveRupees, coinReturn
  );

endinterface

// File: rtl/coin_input_debounce.sv
// One coin sensor channel: synchronizer, stability-count debouncer and
// rising-edge detect producing a single-cycle registered coin_event.
module coin_input_debounce
  import coin_pulse_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic coin_event
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   event_q, event_d;

  // Level toggles on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[SYNC_STAGES-1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    event_d = level_d & ~level_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  assign coin_event = event_q;

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Turns three bouncing coin sensors into clean, spaced, single-cycle coin
// pulses for the vending FSM; rejects coins during delivery via coinReturn.
module coin_pulse_conditioner
  import coin_pulse_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  coin_pulse_conditioner_if.slave  bus
);

  localparam int unsigned GW = cnt_width(GAP_CYCLES);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] ev;

  issue_state_e      state_q, state_d;
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [NUM_CH-1:0] coin_q, coin_d;
  logic              ret_q, ret_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [NUM_CH-1:0] issue_sel;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] dup;
  logic [NUM_CH-1:0] prod_rej;
  logic [NUM_CH-1:0] take;

  assign raw_vec[CH_FIVE]       = bus.rawFive;
  assign raw_vec[CH_TEN]        = bus.rawTen;
  assign raw_vec[CH_TWENTYFIVE] = bus.rawTwentyFive;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coin_input_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clock      (clock),
      .reset      (reset),
      .raw        (raw_vec[i]),
      .coin_event (ev[i])
    );
  end

  // Issue FSM plus pending-flag and coinReturn bookkeeping.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    coin_d    = '0;
    issue_sel = '0;

    case (state_q)
      IDLE: begin
        if (!bus.theProduct && (flag_q != '0)) begin
          if (flag_q[CH_TWENTYFIVE])  issue_sel[CH_TWENTYFIVE] = 1'b1;
          else if (flag_q[CH_TEN])    issue_sel[CH_TEN]        = 1'b1;
          else                        issue_sel[CH_FIVE]       = 1'b1;
          coin_d  = issue_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = GW'(GAP_CYCLES);
        state_d = GAP;
      end
      GAP: begin
        // The IDLE decision cycle is the last idle cycle of the gap.
        gap_d = gap_q - GW'(1);
        if (gap_d <= GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flag cleared by this cycle's issue may be re-set without a return.
    pend     = flag_q & ~issue_sel;
    dup      = ev & pend;
    prod_rej = ev & {NUM_CH{bus.theProduct}};
    take     = ev & ~pend & ~{NUM_CH{bus.theProduct}};
    flag_d   = pend | take;
    ret_d    = |(dup | prod_rej);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      flag_q  <= '0;
      coin_q  <= '0;
      ret_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      coin_q  <= coin_d;
      ret_q   <= ret_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.fiveRupees       = coin_q[CH_FIVE];
  assign bus.tenRupees        = coin_q[CH_TEN];
  assign bus.twentyFiveRupees = coin_q[CH_TWENTYFIVE];
  assign bus.coinReturn       = ret_q;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Directed scoreboard bench for coin_pulse_conditioner: stimulus pushes the
// expected output vector and cycle, a negedge monitor pops and compares.
module tb_coin_pulse_conditioner;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  vec;   // {coinReturn, twentyFive, ten, five}
  } exp_t;

  logic        clock;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          prev_coin = 1'b0;
  exp_t        sb_q[$];

  coin_pulse_conditioner_if bus();

  coin_pulse_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .GAP_CYCLES      (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input int unsigned at, input logic [3:0] v);
    exp_t e;
    e.cyc = at;
    e.vec = v;
    sb_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    logic [3:0] v;
    v = {bus.coinReturn, bus.twentyFiveRupees, bus.tenRupees, bus.fiveRupees};
    checks++;
    if (v != 4'b0000) begin
      errors++;
      $display("FAIL %s: outputs=%b required=0000", name, v);
    end
  endtask

  // Monitor: every nonzero output cycle must match the head of the scoreboard.
  always @(negedge clock) begin
    logic [3:0] v;
    exp_t       e;
    v = {bus.coinReturn, bus.twentyFiveRupees, bus.tenRupees, bus.fiveRupees};
    if (mon_en) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_output: expected %b at cyc=%0d, not observed by cyc=%0d",
                 e.vec, e.cyc, cyc);
      end
    end
    if (mon_en && !reset) begin
      if (v != 4'b0000) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: cyc=%0d got=%b required none", cyc, v);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cyc || e.vec != v) begin
            errors++;
            $display("FAIL scoreboard: cyc=%0d got=%b required %b at cyc=%0d",
                     cyc, v, e.vec, e.cyc);
          end
        end
      end
      if (v[2:0] != 3'b000) begin
        checks++;
        if (prev_coin || ($countones(v[2:0]) > 1)) begin
          errors++;
          $display("FAIL coin_invariant: cyc=%0d coins=%b prev_coin=%0b required one-hot, not back-to-back",
                   cyc, v[2:0], prev_coin);
        end
      end
      prev_coin = |v[2:0];
    end else begin
      prev_coin = 1'b0;
    end
  end

  initial begin
    int unsigned c;
    reset             = 1'b1;
    bus.rawFive       = 1'b0;
    bus.rawTen        = 1'b0;
    bus.rawTwentyFive = 1'b0;
    bus.theProduct    = 1'b0;

    tick(3);
    check_idle("reset_hold");
    reset = 1'b0;
    check_idle("post_reset");
    mon_en = 1'b1;
    tick(5);

    // Clean 10-cycle rawTen pulse.
    c = cyc;
    bus.rawTen = 1'b1;
    expect_out(c + 8, 4'b0010);
    tick(10);
    bus.rawTen = 1'b0;
    tick(20);

    // Bounce 1/0/1, then stable high; only the final rise counts.
    c = cyc;
    bus.rawFive = 1'b1;
    tick(1);
    bus.rawFive = 1'b0;
    tick(1);
    bus.rawFive = 1'b1;
    expect_out(c + 10, 4'b0001);
    tick(11);
    bus.rawFive = 1'b0;
    tick(20);

    // Three coins in the same cycle: priority order, 3 cycles apart.
    c = cyc;
    bus.rawFive       = 1'b1;
    bus.rawTen        = 1'b1;
    bus.rawTwentyFive = 1'b1;
    expect_out(c + 8,  4'b0100);
    expect_out(c + 11, 4'b0010);
    expect_out(c + 14, 4'b0001);
    tick(8);
    bus.rawFive       = 1'b0;
    bus.rawTen        = 1'b0;
    bus.rawTwentyFive = 1'b0;
    tick(25);

    // Coin during delivery is returned, never issued.
    c = cyc;
    bus.theProduct = 1'b1;
    tick(1);
    bus.rawTen = 1'b1;
    expect_out(c + 8, 4'b1000);
    tick(8);
    bus.rawTen = 1'b0;
    tick(12);
    bus.theProduct = 1'b0;
    tick(20);

    // First five held by delivery, second five returned, one five after.
    c = cyc;
    bus.rawFive = 1'b1;
    tick(7);
    bus.theProduct = 1'b1;
    tick(3);
    bus.rawFive = 1'b0;
    tick(10);
    bus.rawFive = 1'b1;
    expect_out(c + 27, 4'b1000);
    tick(10);
    bus.theProduct = 1'b0;
    bus.rawFive    = 1'b0;
    expect_out(c + 31, 4'b0001);
    tick(20);

    // Reset mid-GAP discards the pending ten.
    c = cyc;
    bus.rawTwentyFive = 1'b1;
    bus.rawTen        = 1'b1;
    expect_out(c + 8, 4'b0100);
    tick(9);
    reset             = 1'b1;
    bus.rawTwentyFive = 1'b0;
    bus.rawTen        = 1'b0;
    #1;
    check_idle("reset_mid_gap");
    tick(3);
    reset = 1'b0;
    check_idle("release_mid_gap");
    tick(20);
    c = cyc;
    bus.rawFive = 1'b1;
    expect_out(c + 8, 4'b0001);
    tick(10);
    bus.rawFive = 1'b0;
    tick(20);

    // Sensor held high through reset release counts as one coin.
    reset = 1'b1;
    bus.rawTwentyFive = 1'b1;
    tick(3);
    check_idle("reset_with_sensor_high");
    reset = 1'b0;
    c = cyc;
    expect_out(c + 8, 4'b0100);
    tick(10);
    bus.rawTwentyFive = 1'b0;
    tick(20);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_pulse_conditioner.md
Name: coin_pulse_conditioner

Overview:
- Sits directly upstream of the vending-machine Moore FSM.
- Converts three raw, asynchronous, bouncing coin-sensor lines into clean single-cycle pulses: fiveRupees, tenRupees, twentyFiveRupees.
- Guarantees at most one coin pulse per cycle, with a minimum idle gap between pulses.
- Rejects coins (coinReturn pulse) while the FSM is delivering a product.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per raw input (min 2).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change (min 1).
- GAP_CYCLES, 2, idle cycles forced after every issued coin pulse (min 1).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rawFive  input  1  raw 5-rupee sensor, asynchronous, bouncing, high = coin present.
- rawTen  input  1  raw 10-rupee sensor, same properties.
- rawTwentyFive  input  1  raw 25-rupee sensor, same properties.
- theProduct  input  1  product-delivery indication fed back from the downstream FSM.
- fiveRupees  output  1  single-cycle accepted 5-rupee pulse.
- tenRupees  output  1  single-cycle accepted 10-rupee pulse.
- twentyFiveRupees  output  1  single-cycle accepted 25-rupee pulse.
- coinReturn  output  1  single-cycle pulse; a coin event was rejected.

Behaviour:
- Reset (async, active-high): all sync flops, debounced levels, counters and pending flags clear; FSM enters IDLE. All four outputs are 0 during and immediately after reset.
- Per channel:
  - A SYNC_STAGES-deep synchronizer feeds the debouncer.
  - Debouncer: the counter increments while the synchronized value differs from the debounced level and clears when they match. At DEBOUNCE_CYCLES the debounced level toggles and the counter clears.
  - A coin event is the 0->1 transition of the debounced level. Falling edges produce nothing.
- Pending flags: one per channel, set by a coin event.
  - Event while that channel's flag is already set: coinReturn pulses next cycle; the flag stays set (only one coin is queued per denomination).
  - Event while theProduct=1: the flag is not set and coinReturn pulses next cycle.
- Issue FSM (registered outputs):
  - IDLE: if theProduct=0 and any flag is set, select by fixed priority twentyFive > ten > five, clear the selected flag, and go to ISSUE.
  - ISSUE: the selected output is high for exactly this one cycle. Load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: decrement the counter each cycle; go to IDLE when it reaches 0. No pulses are issued.
- Latency:
  - Raw edge to output pulse is SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles when IDLE, no contention, and theProduct=0.
  - With N coins pending, they are issued in priority order, each separated by GAP_CYCLES idle cycles.
- theProduct high in IDLE: flags set before delivery are held, not issued, until theProduct returns to 0.
- Simultaneous events:
  - Several channels in one cycle: all flags set, issued in priority order.
  - Event on a channel in the same cycle its flag is cleared by the issue FSM: the flag is re-set (no loss, no coinReturn).
  - coinReturn events in the same cycle merge into one pulse.
- Invariants (hold every cycle): at most one of fiveRupees/tenRupees/twentyFiveRupees is high; coin outputs are never high in consecutive cycles.
- Reset mid-operation: pending coins are discarded and no pulse is emitted. A sensor held high through reset release is debounced to high and counts as one new coin.

Decomposition:
- Shared package holds:
  - issue FSM state encoding: IDLE=2'b00, ISSUE=2'b01, GAP=2'b10; default returns to IDLE.
  - channel index constants: CH_FIVE=0, CH_TEN=1, CH_TWENTYFIVE=2.
  - counter-width helper (clog2).
- One sub-module, coin_input_debounce, instantiated three times: synchronizer plus debouncer plus rising-edge detect. Ports: clock, reset, raw, event.
- The top level owns the pending flags, the issue FSM and coinReturn.

Test Plan:
- Defaults. Clean rawTen pulse 10 cycles wide -> exactly one tenRupees pulse, 8 cycles after the sampled rise; no other outputs.
- rawFive bouncing 0/1 every cycle for 3 cycles, then stable high 10 cycles -> exactly one fiveRupees; bounces shorter than 4 cycles produce nothing.
- rawFive, rawTen and rawTwentyFive rise in the same cycle -> twentyFiveRupees, then tenRupees 3 cycles later, then fiveRupees 3 cycles later; never two outputs in one cycle.
- theProduct=1 and rawTen pulse debounces during delivery -> coinReturn single pulse; no tenRupees after theProduct falls.
- Second rawFive coin debounced while the first is still pending (first blocked by theProduct=1) -> one coinReturn. After theProduct falls, exactly one fiveRupees.
- reset asserted asynchronously mid-GAP with a flag pending -> outputs 0 immediately; the pending coin is never issued; the next clean coin is issued normally.
